// File: rtl/systolic_job_sequencer.sv
// rtl/systolic_job_sequencer.sv - job sequencer feeding operands into and reading results out of a systolic accelerator
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   go                              job request pulse, ignored unless idle
//   in_valid, in_ready, in_data     operand byte stream (accepted on in_valid & in_ready)
//   out_valid, out_ready, out_data  result word stream (consumed on out_valid & out_ready)
//   busy, job_done, err             job status: running, end-of-job pulse, timeout flag
//   w_addr, w_data_in, w_write_en   accelerator byte write port
//   w_read_en, w_data_out           accelerator byte read port (data valid the cycle after w_read_en)
//   w_start, w_ready, w_done        accelerator start pulse, idle indication, completion
module systolic_job_sequencer #(
  parameter int N_LOAD    = 48,
  parameter int RES_BASE  = 48,
  parameter int RES_WORDS = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        job_done,
  output logic        err,
  output logic [5:0]  w_addr,
  output logic [7:0]  w_data_in,
  output logic        w_write_en,
  output logic        w_read_en,
  output logic        w_start,
  input  logic [7:0]  w_data_out,
  input  logic        w_ready,
  input  logic        w_done
);

  localparam int         CW = $clog2(TIMEOUT + 1);
  localparam logic [5:0] RB = 6'(RES_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_START, S_WAIT_DONE, S_READ, S_OUTPUT, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    word_q, word_d;
  logic [1:0]    rd_byte_q, rd_byte_d;
  logic          rd_phase_q, rd_phase_d;   // 0: read strobe cycle, 1: sample cycle
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          busy_q, busy_d;
  logic          job_done_q, job_done_d;
  logic          err_q, err_d;
  logic [5:0]    w_addr_q, w_addr_d;
  logic [7:0]    w_data_in_q, w_data_in_d;
  logic          w_write_en_q, w_write_en_d;
  logic          w_read_en_q, w_read_en_d;
  logic          w_start_q, w_start_d;

  logic          accept;

  function automatic logic [5:0] rd_addr(input logic [3:0] w, input logic [1:0] b);
    return RB + {w, 2'b00} + {4'b0000, b};
  endfunction

  assign accept = (state_q == S_LOAD) && in_ready_q && in_valid;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    rd_byte_d    = rd_byte_q;
    rd_phase_d   = rd_phase_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    w_addr_d     = w_addr_q;
    w_data_in_d  = w_data_in_q;
    w_write_en_d = 1'b0;
    w_read_en_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d    = S_WAIT_RDY;
          err_d      = 1'b0;
          byte_cnt_d = '0;
          word_d     = '0;
          rd_byte_d  = '0;
          rd_phase_d = 1'b0;
          wait_cnt_d = '0;
        end
      end
      S_WAIT_RDY: begin
        if (w_ready) state_d = S_LOAD;
      end
      S_LOAD: begin
        // The write for byte k goes out the cycle after it is accepted; once all
        // bytes are in, in_ready is already low and the final write is in flight.
        if (accept) begin
          w_write_en_d = 1'b1;
          w_addr_d     = byte_cnt_q[5:0];
          w_data_in_d  = in_data;
          byte_cnt_d   = byte_cnt_q + 7'd1;
        end else if (byte_cnt_q == 7'(N_LOAD)) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d    = S_WAIT_DONE;
        wait_cnt_d = '0;
      end
      S_WAIT_DONE: begin
        if (w_done) begin
          state_d     = S_READ;
          w_read_en_d = 1'b1;
          w_addr_d    = rd_addr(word_q, 2'd0);
          rd_byte_d   = 2'd0;
          rd_phase_d  = 1'b0;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          out_data_d[8*rd_byte_q +: 8] = w_data_out;
          if (rd_byte_q == 2'd3) begin
            state_d     = S_OUTPUT;
            out_valid_d = 1'b1;
          end else begin
            rd_byte_d   = rd_byte_q + 2'd1;
            rd_phase_d  = 1'b0;
            w_read_en_d = 1'b1;
            w_addr_d    = rd_addr(word_q, rd_byte_q + 2'd1);
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (word_q == 4'(RES_WORDS - 1)) begin
            state_d = S_FINISH;
          end else begin
            state_d     = S_READ;
            word_d      = word_q + 4'd1;
            rd_byte_d   = 2'd0;
            rd_phase_d  = 1'b0;
            w_read_en_d = 1'b1;
            w_addr_d    = rd_addr(word_q + 4'd1, 2'd0);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Level outputs are registered from the next state so they line up with state_q.
    in_ready_d = (state_d == S_LOAD) && (byte_cnt_d != 7'(N_LOAD));
    busy_d     = (state_d != S_IDLE);
    w_start_d  = (state_d == S_START);
    job_done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      rd_byte_q    <= '0;
      rd_phase_q   <= 1'b0;
      wait_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      job_done_q   <= 1'b0;
      err_q        <= 1'b0;
      w_addr_q     <= '0;
      w_data_in_q  <= '0;
      w_write_en_q <= 1'b0;
      w_read_en_q  <= 1'b0;
      w_start_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      rd_byte_q    <= rd_byte_d;
      rd_phase_q   <= rd_phase_d;
      wait_cnt_q   <= wait_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      job_done_q   <= job_done_d;
      err_q        <= err_d;
      w_addr_q     <= w_addr_d;
      w_data_in_q  <= w_data_in_d;
      w_write_en_q <= w_write_en_d;
      w_read_en_q  <= w_read_en_d;
      w_start_q    <= w_start_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign job_done   = job_done_q;
  assign err        = err_q;
  assign w_addr     = w_addr_q;
  assign w_data_in  = w_data_in_q;
  assign w_write_en = w_write_en_q;
  assign w_read_en  = w_read_en_q;
  assign w_start    = w_start_q;

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// tb/tb_systolic_job_sequencer.sv - self-checking bench for systolic_job_sequencer
module tb_systolic_job_sequencer;

  localparam int N_LOAD    = 48;
  localparam int RES_BASE  = 48;
  localparam int RES_WORDS = 4;
  localparam int TIMEOUT   = 1024;

  logic        clk = 1'b0;
  logic        rst, go, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic        busy, job_done, err;
  logic [5:0]  w_addr;
  logic [7:0]  w_data_in, w_data_out;
  logic        w_write_en, w_read_en, w_start, w_ready, w_done;

  always #5 clk = ~clk;

  systolic_job_sequencer #(
    .N_LOAD(N_LOAD), .RES_BASE(RES_BASE), .RES_WORDS(RES_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .job_done(job_done), .err(err),
    .w_addr(w_addr), .w_data_in(w_data_in), .w_write_en(w_write_en),
    .w_read_en(w_read_en), .w_start(w_start), .w_data_out(w_data_out),
    .w_ready(w_ready), .w_done(w_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference computation: A = bytes 0..31 (4x8), B column 0 = even bytes 32..46,
  // plus one B odd byte placed in the top lane so every output byte lane is exercised.
  function automatic logic [31:0] calc_word(input logic [7:0] b [64], input int i);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < 8; k++) s += 32'(b[8*i+k]) * 32'(b[32+2*k]);
    s += {b[32+2*i+1], 24'h0};
    return s;
  endfunction

  // Accelerator model: byte memory, registered read, results computed at w_start.
  logic [7:0] mem [64];
  int acc_lat = 4;
  int acc_timer = 0;

  initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    w_done <= 1'b0;
    if (rst) begin
      acc_timer <= 0;
    end else begin
      if (w_write_en) mem[w_addr] <= w_data_in;
      if (w_read_en) w_data_out <= mem[w_addr];
      if (w_start) begin
        for (int i = 0; i < RES_WORDS; i++)
          for (int j = 0; j < 4; j++) mem[RES_BASE+4*i+j] <= calc_word(mem, i) >> (8*j);
        acc_timer <= (acc_lat > 0) ? acc_lat : 0;
      end else if (acc_timer > 0) begin
        acc_timer <= acc_timer - 1;
        if (acc_timer == 1) w_done <= 1'b1;
      end
    end
  end

  // Scoreboards and monitors
  typedef struct packed { logic [5:0] a; logic [7:0] d; } wr_t;
  wr_t         wr_q [$];
  logic [31:0] exp_q [$];
  wr_t         wr_e;
  logic [31:0] exp_w;
  logic [5:0]  exp_rd_addr;
  int done_cnt, rd_cnt, ov_cnt, start_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_excl", 64'($countones({w_write_en, w_read_en, w_start}) > 1), 64'd0);
      if (w_write_en) begin
        if (wr_q.size() == 0) chk("unexpected_write", 64'(w_addr), 64'hFFFF);
        else begin
          wr_e = wr_q.pop_front();
          chk("wr_addr", 64'(w_addr), 64'(wr_e.a));
          chk("wr_data", 64'(w_data_in), 64'(wr_e.d));
        end
      end
      if (w_start) begin
        start_cnt++;
        chk("start_after_writes", 64'(wr_q.size()), 64'd0);
      end
      if (w_read_en) begin
        rd_cnt++;
        chk("rd_addr", 64'(w_addr), 64'(exp_rd_addr));
        chk("rd_during_output", 64'(out_valid), 64'd0);
        exp_rd_addr = exp_rd_addr + 6'd1;
      end
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF);
        else begin
          exp_w = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(exp_w));
        end
      end
      if (job_done) done_cnt++;
    end
  end

  // Stimulus
  typedef struct {
    int pat;        // 0: simple job bytes, 1: random, 2: incrementing
    int lat;        // w_done latency after w_start, <=0: never
    int bp;         // cycles out_ready held low on word 0
    int rdy_delay;  // cycles w_ready held low after go
    bit go_busy;    // hold go high for the whole job
    bit exp_err;    // expected outputs: timeout flag (no words when set)
  } vec_t;

  vec_t vecs [5];
  logic [7:0] stream [64];

  function automatic logic [53:0] all_outs();
    return {in_ready, out_valid, out_data, busy, job_done, err,
            w_addr, w_data_in, w_write_en, w_read_en, w_start};
  endfunction

  task automatic prepare(input vec_t v);
    for (int k = 0; k < 64; k++) stream[k] = 8'h00;
    for (int k = 0; k < N_LOAD; k++)
      case (v.pat)
        1:       stream[k] = 8'($urandom);
        2:       stream[k] = 8'(k + 1);
        default: stream[k] = 8'h00;
      endcase
    if (v.pat == 0) begin
      stream[0] = 8'd1; stream[2] = 8'd1;
      stream[32] = 8'd2; stream[36] = 8'd3;
    end
    wr_q.delete();
    exp_q.delete();
    for (int k = 0; k < N_LOAD; k++) wr_q.push_back('{6'(k), stream[k]});
    if (!v.exp_err)
      for (int i = 0; i < RES_WORDS; i++) exp_q.push_back(calc_word(stream, i));
    acc_lat = v.lat;
    done_cnt = 0; rd_cnt = 0; ov_cnt = 0; start_cnt = 0;
    exp_rd_addr = 6'(RES_BASE);
  endtask

  task automatic start_job(input vec_t v);
    @(posedge clk); #1;
    go = 1'b1;
    w_ready = (v.rdy_delay == 0);
    @(posedge clk); #1;
    go = v.go_busy;
    chk("busy_after_go", 64'(busy), 64'd1);
    chk("err_cleared_by_go", 64'(err), 64'd0);
    for (int d = 0; d < v.rdy_delay; d++) begin
      in_valid = 1'b1;
      in_data = stream[0];
      @(negedge clk);
      chk("no_load_before_rdy", 64'({in_ready, w_write_en}), 64'd0);
      @(posedge clk); #1;
    end
    w_ready = 1'b1;
  endtask

  task automatic stream_bytes(input int n);
    bit acc;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data = stream[k];
      acc = 1'b0;
      for (int c = 0; c < 100 && !acc; c++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        chk("accept_timeout", 64'(k), 64'hFFFF);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input vec_t v);
    bit seen;
    int stall;
    logic [31:0] cap;
    seen = 1'b0;
    stall = 0;
    cap = '0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      if (job_done) begin
        seen = 1'b1;
        go = 1'b0;
        out_ready = 1'b0;
        chk("err_at_done", 64'(err), 64'(v.exp_err));
      end else if (out_valid) begin
        if (stall < v.bp) begin
          out_ready = 1'b0;
          if (stall == 0) cap = out_data;
          else chk("bp_stable", 64'({out_valid, out_data}), 64'({1'b1, cap}));
          stall++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (!seen) chk("job_done_timeout", 64'd0, 64'd1);
    go = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("start_count", 64'(start_cnt), 64'd1);
    chk("read_count", 64'(rd_cnt), v.exp_err ? 64'd0 : 64'(4 * RES_WORDS));
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("writes_left", 64'(wr_q.size()), 64'd0);
    if (v.exp_err) chk("no_out_valid", 64'(ov_cnt), 64'd0);
    chk("idle_after_job", 64'({busy, err}), 64'({1'b0, v.exp_err}));
  endtask

  task automatic run_job(input vec_t v);
    prepare(v);
    start_job(v);
    stream_bytes(N_LOAD);
    finish_job(v);
  endtask

  initial begin
    vecs[0] = '{0,  5,  0, 0, 1'b0, 1'b0};  // simple job, word0 = 5
    vecs[1] = '{1,  3, 10, 0, 1'b0, 1'b0};  // random operands, backpressure on word0
    vecs[2] = '{2, 20,  2, 5, 1'b1, 1'b0};  // w_ready late, go held while busy
    vecs[3] = '{1, -1,  0, 0, 1'b0, 1'b1};  // accelerator never completes
    vecs[4] = '{1,  1,  0, 0, 1'b0, 1'b0};  // next job clears err

    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; w_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_job(vecs[i]);

    // Reset in the middle of LOAD, right after byte 20 is accepted.
    prepare(vecs[1]);
    start_job(vecs[1]);
    stream_bytes(21);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midload_reset_outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    wr_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("no_strobe_after_reset", 64'({w_write_en, w_read_en, w_start, busy}), 64'd0);
    run_job(vecs[0]);
    run_job(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_job_sequencer.md
SYSTOLIC_JOB_SEQUENCER -- requirements
Module: systolic_job_sequencer

Interface
REQ-001 SHALL have parameters: N_LOAD 48, number of operand bytes loaded per job; RES_BASE 48, first result byte address; RES_WORDS 4, 32-bit result words read per job; TIMEOUT 1024, maximum cycles to wait for w_done.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  job request pulse
- in_valid  in  1  operand byte valid
- in_data  in  8  operand byte
- in_ready  out  1  operand byte accepted when in_valid&in_ready
- out_valid  out  1  result word valid
- out_data  out  32  result word
- out_ready  in  1  result word consumed when out_valid&out_ready
- busy  out  1  high whenever state != IDLE
- job_done  out  1  one-cycle pulse at job end
- err  out  1  timeout flag
- w_addr  out  6  accelerator byte address
- w_data_in  out  8  accelerator write data
- w_write_en  out  1  accelerator write strobe
- w_read_en  out  1  accelerator read strobe
- w_start  out  1  accelerator start pulse
- w_data_out  in  8  accelerator read data
- w_ready  in  1  accelerator idle/ready
- w_done  in  1  accelerator computation complete
REQ-003 SHALL drive all outputs from registers.

Function
REQ-004 SHALL implement states IDLE, WAIT_RDY, LOAD, START, WAIT_DONE, READ, OUTPUT, FINISH.
REQ-005 IDLE: go=1 -> WAIT_RDY; clear err, byte and word counters; go in any other state ignored.
REQ-006 WAIT_RDY: remain until w_ready=1, then LOAD.
REQ-007 LOAD: in_ready=1; each accepted byte k (k=0..N_LOAD-1) yields w_addr=k, w_data_in=byte, w_write_en=1 for exactly one cycle on the cycle after acceptance; back-to-back acceptance permitted (one write per cycle).
REQ-008 After the N_LOAD-th accept, in_ready SHALL drop on the next cycle; after the last write strobe -> START.
REQ-009 START: w_start=1 for exactly one cycle, then WAIT_DONE.
REQ-010 WAIT_DONE: count cycles from entry; w_done=1 -> READ; counter reaching TIMEOUT with no w_done -> set err=1, go to FINISH skipping READ/OUTPUT.
REQ-011 READ: for byte j=0..3 of word i, assert w_read_en=1, w_addr=RES_BASE+4*i+j for one cycle; sample w_data_out on the following cycle; w_read_en low during the sample cycle.
REQ-012 Assembly little-endian: byte j -> out_data[8j+7:8j].
REQ-013 After byte 3 sampled -> OUTPUT: out_valid=1, out_data stable until out_valid&out_ready; then i+1 -> READ, or FINISH if i=RES_WORDS-1.
REQ-014 FINISH: job_done=1 one cycle, -> IDLE; err retained until next go.
REQ-015 Address arithmetic 6-bit; RES_BASE+4*RES_WORDS-1 SHALL be <=63 (parameter constraint, not checked at runtime).
REQ-016 w_write_en, w_read_en, w_start mutually exclusive every cycle.

Reset
REQ-017 rst=1 at a clock edge, in any state including mid-LOAD or mid-READ: state IDLE, all outputs 0, counters 0, in-flight job discarded; no strobe issued in the cycle after reset.

Verification
REQ-018 Simple job: stream A bytes {1,0,1,0,0x00 x28}, B bytes {2,0,0,0,3,0 x11}; model sets result word0=5 -> out_data 0x00000005 then three 0x00000000 words, job_done once, err=0.
REQ-019 Write map: 48 back-to-back bytes -> 48 one-cycle w_write_en pulses, addresses 0..47 in order, data matches stream, then one w_start pulse.
REQ-020 Backpressure: out_ready held low 10 cycles on word0 -> out_data/out_valid stable, no w_read_en until accepted.
REQ-021 Timeout: model never raises w_done -> err=1 after TIMEOUT cycles, job_done pulse, no w_read_en, out_valid never high.
REQ-022 Reset mid-LOAD after byte 20 -> all outputs 0 next cycle; new go runs a full correct job.
REQ-023 go asserted while busy -> ignored; w_ready held low 5 cycles after go -> no write until w_ready=1.
